// File: rtl/cpu_pkg.sv
// Shared definitions for the single-cycle MIPS core: next-PC source
// encodings and the default kernel vector addresses.
package cpu_pkg;

   // Next-PC source selected by the control unit
   typedef enum logic [1:0] {
      PCSRC_SEQ = 2'd0,   // PC + 4
      PCSRC_BR  = 2'd1,   // conditional branch
      PCSRC_J   = 2'd2,   // j / jal
      PCSRC_JR  = 2'd3    // jr / jalr
   } pcsrc_e;

   // Kernel-space vectors (PC[31] = 1 marks kernel mode)
   localparam logic [31:0] DEF_RESET_VEC = 32'h8000_0000;
   localparam logic [31:0] DEF_ILLOP_VEC = 32'h8000_0004;
   localparam logic [31:0] DEF_XADR_VEC  = 32'h8000_0008;

endpackage : cpu_pkg

// File: rtl/irq_latch.sv
// Timer interrupt request latch: detects a rising edge on irq, holds it
// pending until the core takes the interrupt, and acknowledges the
// timer for one cycle after the interrupt is taken.
module irq_latch (
   input  logic clk,
   input  logic reset,
   input  logic irq,
   input  logic take,
   output logic pending,
   output logic ack
);

   logic r_irq_q;
   logic r_pending;
   logic r_ack;
   logic w_irq_rise;

   assign w_irq_rise = irq & ~r_irq_q;

   // Edge detector, sticky pending flag (a new edge beats a clear) and ack pulse
   always_ff @(posedge clk) begin
      if (reset) begin
         r_irq_q   <= 1'b0;
         r_pending <= 1'b0;
         r_ack     <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         r_irq_q <= irq;
         r_ack   <= take;
         if (w_irq_rise)
            r_pending <= 1'b1;
         else if (take)
            r_pending <= 1'b0;
      end
   end

   assign pending = r_pending;
   assign ack     = r_ack;

endmodule : irq_latch

// File: rtl/pc_unit.sv
// Program-counter stage: PC register, next-PC selection, kernel-bit
// protection, interrupt/exception qualifiers and the link address.
module pc_unit
   import cpu_pkg::*;
#(
   parameter logic [31:0] RESET_VEC = DEF_RESET_VEC,
   parameter logic [31:0] ILLOP_VEC = DEF_ILLOP_VEC,
   parameter logic [31:0] XADR_VEC  = DEF_XADR_VEC
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [1:0]  PCSrc,
   input  logic        branch_taken,
   input  logic [15:0] imm16,
   input  logic [25:0] jt,
   input  logic [31:0] rs_data,
   input  logic        illegal_op,
   input  logic        irq,
   input  logic        stall,
   output logic [31:0] PC,
   output logic [31:0] pc_plus4,
   output logic [31:0] link_addr,
   output logic        Interrupt,
   output logic        Exception,
   output logic        irq_ack
);

   logic [31:0] r_pc;
   logic [31:0] w_pc_plus4;
   logic [31:0] w_branch_tgt;
   logic [31:0] w_jump_tgt;
   logic [31:0] w_jr_tgt;
   logic [30:0] w_branch_off;
   logic [31:0] w_next_pc;
   logic [31:0] w_next_pc_al;
   logic        w_pending;
   logic        w_interrupt;
   logic        w_exception;

   irq_latch u_irq_latch (
      .clk     (clk),
      .reset   (reset),
      .irq     (irq),
      .take    (w_interrupt),
      .pending (w_pending),
      .ack     (irq_ack)
   );

   // Interrupts are masked in kernel mode and while stalled; they stay pending
   assign w_interrupt = w_pending & ~r_pc[31] & ~stall;
   assign w_exception = illegal_op & ~w_interrupt & ~stall;

   // Address arithmetic wraps inside bits [30:0]; bit 31 is carried through
   assign w_pc_plus4   = {r_pc[31], r_pc[30:0] + 31'd4};
   assign w_branch_off = {{13{imm16[15]}}, imm16, 2'b00};
   assign w_branch_tgt = {r_pc[31], r_pc[30:0] + 31'd4 + w_branch_off};
   assign w_jump_tgt   = {r_pc[31:28], jt, 2'b00};
   // A jr can drop to user mode but never climb into kernel mode
   assign w_jr_tgt     = {r_pc[31] & rs_data[31], rs_data[30:0]};

   // Next-PC priority: stall, interrupt, exception, then the control selection
   always_comb begin
      // NOTE: default first so no path through this block leaves w_next_pc unassigned (no latch).
      w_next_pc = w_pc_plus4;
      if (stall)
         w_next_pc = r_pc;
      else if (w_interrupt)
         w_next_pc = ILLOP_VEC;
      else if (w_exception)
         w_next_pc = XADR_VEC;
      else begin
         case (PCSrc)
            PCSRC_SEQ: w_next_pc = w_pc_plus4;
            PCSRC_BR:  w_next_pc = branch_taken ? w_branch_tgt : w_pc_plus4;
            PCSRC_J:   w_next_pc = w_jump_tgt;
            PCSRC_JR:  w_next_pc = w_jr_tgt;
            default:   w_next_pc = w_pc_plus4;
         endcase
      end
   end

   // Instructions are word aligned, so the two low bits are always cleared
   assign w_next_pc_al = w_next_pc & 32'hFFFF_FFFC;

   // PC register with synchronous reset to the kernel reset vector
   always_ff @(posedge clk) begin
      if (reset)
         r_pc <= RESET_VEC;
      else
         r_pc <= w_next_pc_al;
   end

   assign PC        = r_pc;
   assign pc_plus4  = w_pc_plus4;
   // An interrupted instruction is re-executed, so its own address is saved
   assign link_addr = w_interrupt ? r_pc : w_pc_plus4;
   assign Interrupt = w_interrupt;
   assign Exception = w_exception;

endmodule : pc_unit

// File: tb/tb_pc_unit.sv
// Directed testbench for pc_unit with hand-computed expected values.
module tb_pc_unit;
   import cpu_pkg::*;

   logic        clk;
   logic        reset;
   logic [1:0]  PCSrc;
   logic        branch_taken;
   logic [15:0] imm16;
   logic [25:0] jt;
   logic [31:0] rs_data;
   logic        illegal_op;
   logic        irq;
   logic        stall;
   logic [31:0] PC;
   logic [31:0] pc_plus4;
   logic [31:0] link_addr;
   logic        Interrupt;
   logic        Exception;
   logic        irq_ack;

   int n_cmp;
   int n_err;

   pc_unit dut (
      .clk          (clk),
      .reset        (reset),
      .PCSrc        (PCSrc),
      .branch_taken (branch_taken),
      .imm16        (imm16),
      .jt           (jt),
      .rs_data      (rs_data),
      .illegal_op   (illegal_op),
      .irq          (irq),
      .stall        (stall),
      .PC           (PC),
      .pc_plus4     (pc_plus4),
      .link_addr    (link_addr),
      .Interrupt    (Interrupt),
      .Exception    (Exception),
      .irq_ack      (irq_ack)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
      end
   endtask

   // Advance one clock edge, then settle away from the edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step();
      reset = 1'b0;
   endtask

   // Jump via jr to an address (only user targets are reachable from user mode)
   task automatic go_jr(input logic [31:0] addr);
      PCSrc   = PCSRC_JR;
      rs_data = addr;
      step();
      PCSrc   = PCSRC_SEQ;
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      reset = 1'b1; PCSrc = PCSRC_SEQ; branch_taken = 1'b0; imm16 = '0; jt = '0;
      rs_data = '0; illegal_op = 1'b0; irq = 1'b0; stall = 1'b0;
      step();
      step();
      reset = 1'b0;
      #1;

      // Reset state
      check("rst_pc", PC, 32'h8000_0000);
      check("rst_pc4", pc_plus4, 32'h8000_0004);
      check("rst_int", {31'd0, Interrupt}, 32'd0);
      check("rst_exc", {31'd0, Exception}, 32'd0);
      check("rst_ack", {31'd0, irq_ack}, 32'd0);

      // Sequential fetch from the reset vector
      step(); check("seq1", PC, 32'h8000_0004);
      step(); check("seq2", PC, 32'h8000_0008);
      step(); check("seq3", PC, 32'h8000_000C);

      // Branch taken / not taken with negative offset
      go_jr(32'h0000_0100); check("jr_user", PC, 32'h0000_0100);
      PCSrc = PCSRC_BR; imm16 = 16'hFFFE; branch_taken = 1'b1;
      step(); check("br_taken", PC, 32'h0000_00FC);
      go_jr(32'h0000_0100);
      PCSrc = PCSRC_BR; branch_taken = 1'b0;
      step(); check("br_ntaken", PC, 32'h0000_0104);
      PCSrc = PCSRC_SEQ;

      // jr cannot enter kernel mode; misaligned target is word-aligned
      go_jr(32'h0000_0040);
      go_jr(32'h8000_1000); check("jr_kblock", PC, 32'h0000_1000);
      go_jr(32'h0000_0103); check("jr_align", PC, 32'h0000_0100);
      do_reset();
      step(); step(); step(); step();
      check("seq4", PC, 32'h8000_0010);
      go_jr(32'h0000_2000); check("jr_k2u", PC, 32'h0000_2000);

      // User-mode wrap modulo 2^31, kernel-mode wrap keeps bit 31
      go_jr(32'h7FFF_FFFC); check("wrap_pc4_u", pc_plus4, 32'h0000_0000);
      step(); check("wrap_pc_u", PC, 32'h0000_0000);
      do_reset();
      go_jr(32'hFFFF_FFFC); check("wrap_pc_k", PC, 32'hFFFF_FFFC);
      check("wrap_pc4_k", pc_plus4, 32'h8000_0000);

      // Jump keeps PC[31:28]; jal link is pc_plus4
      do_reset();
      PCSrc = PCSRC_J; jt = 26'd8;
      #1 check("jal_link", link_addr, 32'h8000_0004);
      step(); check("j_tgt", PC, 32'h8000_0020);
      PCSrc = PCSRC_SEQ;

      // User interrupt at 0x200, irq held high afterwards
      go_jr(32'h0000_01FC);
      irq = 1'b1;
      step(); check("irq_pc", PC, 32'h0000_0200);
      check("irq_int", {31'd0, Interrupt}, 32'd1);
      check("irq_link", link_addr, 32'h0000_0200);
      check("irq_exc", {31'd0, Exception}, 32'd0);
      step(); check("irq_vec", PC, 32'h8000_0004);
      check("irq_ack1", {31'd0, irq_ack}, 32'd1);
      check("irq_int_off", {31'd0, Interrupt}, 32'd0);
      go_jr(32'h0000_0200);
      check("irq_ack0", {31'd0, irq_ack}, 32'd0);
      check("irq_held", {31'd0, Interrupt}, 32'd0);
      irq = 1'b0;

      // Kernel mode masks the interrupt until jr to user mode
      do_reset();
      PCSrc = PCSRC_J; jt = 26'd8;
      step(); PCSrc = PCSRC_SEQ;
      irq = 1'b1;
      step(); check("kmask_pc", PC, 32'h8000_0024);
      check("kmask_int1", {31'd0, Interrupt}, 32'd0);
      irq = 1'b0;
      step(); check("kmask_int2", {31'd0, Interrupt}, 32'd0);
      go_jr(32'h0000_0500);
      check("kmask_take", {31'd0, Interrupt}, 32'd1);
      check("kmask_link", link_addr, 32'h0000_0500);
      step(); check("kmask_vec", PC, 32'h8000_0004);
      check("kmask_ack", {31'd0, irq_ack}, 32'd1);

      // Interrupt beats a simultaneous illegal opcode
      go_jr(32'h0000_02FC);
      irq = 1'b1;
      step(); irq = 1'b0; illegal_op = 1'b1;
      #1 check("pri_int", {31'd0, Interrupt}, 32'd1);
      check("pri_exc", {31'd0, Exception}, 32'd0);
      step(); check("pri_vec", PC, 32'h8000_0004);
      illegal_op = 1'b0;

      // Illegal opcode alone
      go_jr(32'h0000_0300);
      illegal_op = 1'b1;
      #1 check("exc_flag", {31'd0, Exception}, 32'd1);
      check("exc_link", link_addr, 32'h0000_0304);
      step(); check("exc_vec", PC, 32'h8000_0008);
      illegal_op = 1'b0;

      // Stall holds PC and blocks the pending interrupt
      go_jr(32'h0000_03FC);
      irq = 1'b1;
      step(); irq = 1'b0;
      stall = 1'b1; PCSrc = PCSRC_J; jt = 26'h123;
      #1 check("stall_int", {31'd0, Interrupt}, 32'd0);
      step(); check("stall_hold1", PC, 32'h0000_0400);
      step(); check("stall_hold2", PC, 32'h0000_0400);
      stall = 1'b0; PCSrc = PCSRC_SEQ;
      #1 check("stall_rel_int", {31'd0, Interrupt}, 32'd1);
      step(); check("stall_rel_vec", PC, 32'h8000_0004);

      // Reset during a stall discards the pending request
      go_jr(32'h0000_04FC);
      irq = 1'b1;
      step(); irq = 1'b0; stall = 1'b1;
      step(); check("rst_st_hold", PC, 32'h0000_0500);
      do_reset();
      stall = 1'b0;
      check("rst_st_pc", PC, 32'h8000_0000);
      go_jr(32'h0000_0600);
      check("rst_st_int", {31'd0, Interrupt}, 32'd0);
      check("rst_st_ack", {31'd0, irq_ack}, 32'd0);

      // Two edges while pending merge into one request
      do_reset();
      irq = 1'b1; step();
      irq = 1'b0; step();
      irq = 1'b1; step();
      irq = 1'b0;
      go_jr(32'h0000_0700);
      check("merge_int1", {31'd0, Interrupt}, 32'd1);
      step();
      go_jr(32'h0000_0700);
      check("merge_int2", {31'd0, Interrupt}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule : tb_pc_unit

// File: doc/pc_unit.md
# pc_unit

Program-counter stage of the single-cycle MIPS core. It holds the PC register, resolves the next PC from the control unit's `PCSrc`, and enforces the PC[31] kernel bit. It latches timer interrupt requests and generates the `Interrupt`/`Exception` qualifiers that the control unit consumes. It also supplies the link/return address for the `MemToReg`=2 write-back path.

## Interface
Parameters:
- `RESET_VEC`, 32'h8000_0000: PC after reset; kernel mode.
- `ILLOP_VEC`, 32'h8000_0004: interrupt handler entry.
- `XADR_VEC`, 32'h8000_0008: exception handler entry.

Ports:
- `clk`  in  1  core clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `PCSrc`  in  2  from control: 0 seq, 1 branch, 2 j/jal, 3 jr/jalr.
- `branch_taken`  in  1  ALU compare result; used only when `PCSrc`=1.
- `imm16`  in  16  branch offset, in words.
- `jt`  in  26  jump target field.
- `rs_data`  in  32  register-file rs value for jr/jalr.
- `illegal_op`  in  1  decoder flag for an undefined opcode/funct.
- `irq`  in  1  level request from the timer peripheral.
- `stall`  in  1  hold the PC this cycle; no interrupt or exception is taken.
- `PC`  out  32  current PC; drives instruction memory.
- `pc_plus4`  out  32  {PC[31], PC[30:0]+4}.
- `link_addr`  out  32  value written to $ra/$26.
- `Interrupt`  out  1  to control.
- `Exception`  out  1  to control.
- `irq_ack`  out  1  one-cycle acknowledge to the timer.

## Operation
- Kernel mode is defined as `PC[31]`=1.
- `irq` edge detection:
  - `irq_q` is a registered copy of `irq`.
  - `irq_pending` is set on `irq & ~irq_q`.
  - `irq_pending` is cleared in the cycle `Interrupt` is taken.
  - If set and clear occur in the same cycle, set wins.
- `Interrupt` = `irq_pending & ~PC[31] & ~stall`. Interrupts are masked in kernel mode and remain pending.
- `Exception` = `illegal_op & ~Interrupt & ~stall`, in either mode. Interrupt has priority over exception.
- Next-PC priority:
  1. `reset` → `RESET_VEC`.
  2. `stall` → hold.
  3. `Interrupt` → `ILLOP_VEC`.
  4. `Exception` → `XADR_VEC`.
  5. `PCSrc` selection:
     - 0 → `pc_plus4`.
     - 1 → taken: {PC[31], PC[30:0]+4+(sext(imm16)<<2)}; not taken: `pc_plus4`.
     - 2 → {PC[31:28], jt, 2'b00}.
     - 3 → {PC[31] & rs_data[31], rs_data[30:0]}. User code cannot enter kernel mode via jr; the handler returns to user mode with jr $26.
- PC arithmetic:
  - Performed on bits [30:0], modulo 2^31.
  - Bit 31 is preserved, except on a vector load or `PCSrc`=3.
  - PC[1:0] is always forced to 0.
- `link_addr`:
  - `Interrupt` → `PC`, so the interrupted instruction is re-executed.
  - `Exception` → `pc_plus4`.
  - Otherwise → `pc_plus4`, for jal/jalr.
- `irq_ack` is registered: it goes high the cycle after an interrupt is taken, for one cycle.

## Timing
- Reset values:
  - `PC`=`RESET_VEC`.
  - `irq_q`=0, `irq_pending`=0, `irq_ack`=0.
  - `Interrupt`=0; `Exception`=0 unless `illegal_op`.
  - `pc_plus4`=`RESET_VEC`+4.
- Next-PC logic is combinational from inputs and `PC`. The PC updates on the edge, giving 1-cycle latency from `PCSrc`/`branch_taken` to the new `PC`.
- `irq` rising edge at cycle n → `irq_pending` set at n+1. In user mode with no stall, `Interrupt` is high during n+1, `PC`=`ILLOP_VEC` at n+2, and `irq_ack`=1 at n+2.
- Boundary behaviour:
  - A `reset` asserted mid-`stall` or mid-pending discards pending state.
  - An `irq` held high produces only one request.
  - A second rising edge while the first is still pending is merged into it.

## Structure
- Shared package `cpu_pkg`:
  - PCSrc encodings: `PCSRC_SEQ`, `PCSRC_BR`, `PCSRC_J`, `PCSRC_JR`.
  - Default vector constants.
- Sub-module `irq_latch`: edge detector, pending flag and `irq_ack` register. Its inputs are `clk`, `reset`, `irq` and `take`; its outputs are `pending` and `ack`.
- The PC register and next-PC mux live in `pc_unit`.

## Test plan
- Reset, then 3 cycles with `PCSrc`=0 → `PC` = 8000_0000, 8000_0004, 8000_0008, 8000_000C.
- User `PC`=0000_0100, `PCSrc`=1, `imm16`=16'hFFFE:
  - `branch_taken`=1 → next `PC`=0000_00FC.
  - `branch_taken`=0 → next `PC`=0000_0104.
- `PCSrc`=3:
  - `PC`=0000_0040, `rs_data`=8000_1000 → next `PC`=0000_1000 (kernel blocked).
  - `PC`=8000_0010, `rs_data`=0000_2000 → next `PC`=0000_2000.
- `irq` pulse at user `PC`=0000_0200:
  - Expect `Interrupt` for 1 cycle, `link_addr`=0000_0200, next `PC`=8000_0004, then `irq_ack`=1 for one cycle.
  - Repeat with `PC`=8000_0020: expect no `Interrupt` until a jr to user mode, then it is taken.
- `illegal_op` and `irq` edge in the same user cycle → interrupt taken first with `Exception`=0. `illegal_op` at `PC`=0000_0300 alone → `link_addr`=0000_0304, next `PC`=8000_0008.
- `stall`=1 with `irq` pending and `PCSrc`=2 → `PC` is held and `Interrupt`=0. On release, the interrupt is taken. `reset` during a stall → `PC`=8000_0000 with pending cleared.
